// File: rtl/card_deck.sv
// 52-card dealer: LFSR-driven Fisher-Yates shuffle behind a four-phase
// deckDeal/deckDealt handshake, with auto-refill when the deck runs out.
module card_deck #(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter bit          SHUFFLE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       deckDeal,
    output logic       deckDealt,
    output logic [3:0] rankOut,
    output logic [1:0] suitOut,
    input  logic       shuffle,
    output logic       busy,
    output logic [5:0] cardsLeft
);
    typedef enum logic [1:0] {INIT, SHUF, IDLE, HOLD} state_t;

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [5:0]  LAST     = 6'd51;
    localparam logic [5:0]  FULL     = 6'd52;

    state_t      state, state_n;
    logic [5:0]  cards [52];
    logic [5:0]  k, i, ptr;
    logic [15:0] lfsr;
    logic        pend;

    logic [5:0]  j;
    logic        pend_any, init_last, shuf_hit, shuf_last;
    logic        init_done, shuf_done, do_swap;
    logic        do_deal, do_refill, do_release;
    logic [5:0]  deal_idx;
    logic [3:0]  deal_off, deal_rank;
    logic [1:0]  deal_suit;

    assign j         = lfsr[5:0];
    assign pend_any  = pend | shuffle;
    assign init_last = (k == LAST);
    assign shuf_hit  = (j <= i);
    assign shuf_last = shuf_hit && (i == 6'd1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else        state <= state_n;
    end

    // Next-state selection
    always_comb begin
        state_n = state;
        case (state)
            INIT: if (init_last)
                      state_n = (SHUFFLE_EN && pend) ? SHUF : IDLE;
            SHUF: if (shuf_last) state_n = IDLE;
            IDLE: begin
                if (pend_any)
                    state_n = SHUFFLE_EN ? SHUF : INIT;
                else if (deckDeal && ptr == FULL)
                    state_n = INIT;
                else if (deckDeal)
                    state_n = HOLD;
            end
            HOLD: if (!deckDeal) state_n = IDLE;
            default: state_n = INIT;
        endcase
    end

    // State-decoded strobes and the busy flag
    always_comb begin
        busy       = (state == INIT) || (state == SHUF);
        init_done  = (state == INIT) && init_last;
        shuf_done  = (state == SHUF) && shuf_last;
        do_swap    = (state == SHUF) && shuf_hit;
        do_deal    = (state == IDLE) && !pend_any && deckDeal && (ptr != FULL);
        do_refill  = (state == IDLE) && !pend_any && deckDeal && (ptr == FULL);
        do_release = (state == HOLD) && !deckDeal;
    end

    // Free-running Galois LFSR, right shift, taps 16'hB400
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= SEED_EFF;
        else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // Card store: ordered fill in INIT, swaps in SHUF
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 52; n++) cards[n] <= '0;
        end else if (state == INIT) begin
            cards[k] <= k;
        end else if (do_swap) begin
            cards[i] <= cards[j];
            cards[j] <= cards[i];
        end
    end

    // Fill index, shuffle index, deal pointer, remaining count, pending flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k         <= '0;
            i         <= LAST;
            ptr       <= '0;
            cardsLeft <= '0;
            pend      <= 1'b1;
        end else begin
            if (state == INIT) k <= init_last ? 6'd0 : k + 6'd1;
            if (do_swap)       i <= shuf_last ? LAST : i - 6'd1;
            if (init_done || shuf_done) begin
                ptr       <= '0;
                cardsLeft <= FULL;
            end else if (do_deal) begin
                ptr <= ptr + 6'd1;
                if (cardsLeft != 6'd0) cardsLeft <= cardsLeft - 6'd1;
            end
            if (shuffle || do_refill)
                pend <= 1'b1;
            else if (shuf_done || (init_done && !SHUFFLE_EN))
                pend <= 1'b0;
        end
    end

    // Split the card index into suit and rank; the rank only needs the low
    // nibble because (idx - 13*suit) < 13, so offsets are 13*suit mod 16
    always_comb begin
        deal_idx  = cards[ptr];
        deal_suit = 2'd0;
        deal_off  = 4'd0;
        if (deal_idx >= 6'd39) begin
            deal_suit = 2'd3;
            deal_off  = 4'd7;
        end else if (deal_idx >= 6'd26) begin
            deal_suit = 2'd2;
            deal_off  = 4'd10;
        end else if (deal_idx >= 6'd13) begin
            deal_suit = 2'd1;
            deal_off  = 4'd13;
        end
        deal_rank = deal_idx[3:0] - deal_off + 4'd1;
    end

    // Handshake outputs: card latched on deal, deckDealt dropped on release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deckDealt <= 1'b0;
            rankOut   <= '0;
            suitOut   <= '0;
        end else if (do_deal) begin
            deckDealt <= 1'b1;
            rankOut   <= deal_rank;
            suitOut   <= deal_suit;
        end else if (do_release) begin
            deckDealt <= 1'b0;
        end
    end
endmodule
